// File: rtl/ext_snapshot_fifo.sv
// ext_snapshot_fifo: samples an exported register on request into a small FIFO drained over valid/ready
module ext_snapshot_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         ext_data,
  input  logic                     cap,
  input  logic                     clear,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic [7:0]               drop_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] rp, wp;
  logic full, pop, push, drop;
  always_comb begin
    full = count == FULL;
    out_valid = count != '0;
    out_data = out_valid ? mem[rp] : '0;
    pop = out_valid & out_ready;
    push = cap & (~full | pop);
    drop = cap & full & ~pop;
  end
  always_ff @(posedge clk) if (push && !clear) mem[wp] <= ext_data;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rp <= '0;
      wp <= '0;
      count <= '0;
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (clear) begin
      rp <= '0;
      wp <= '0;
      count <= '0;
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else begin
      rp <= rp + AW'(pop);
      wp <= wp + AW'(push);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
      overflow <= overflow | drop;
      drop_cnt <= drop_cnt + 8'(drop && drop_cnt != 8'hff);
    end
  end
endmodule

// File: tb/tb_ext_snapshot_fifo.sv
// tb_ext_snapshot_fifo: directed vector table plus hand sequences for wrap, clear, reset and saturation
module tb_ext_snapshot_fifo;
  logic clk = 0, rst = 1, cap = 0, clear = 0, out_ready = 0;
  logic [31:0] ext_data = 0;
  logic out_valid, overflow;
  logic [31:0] out_data;
  logic [2:0] count;
  logic [7:0] drop_cnt;
  int checks = 0, errors = 0;
  ext_snapshot_fifo dut (.clk(clk), .rst(rst), .ext_data(ext_data), .cap(cap), .clear(clear),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .count(count),
    .overflow(overflow), .drop_cnt(drop_cnt));
  always #5 clk = ~clk;
  typedef struct {
    logic cap, clr, rdy;
    logic [31:0] d;
    logic ev;
    logic [31:0] ed;
    logic [2:0] ec;
    logic eov;
    logic [7:0] edc;
  } vec_t;
  vec_t tv[22];
  logic [31:0] q[$];
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic cyc(input logic c, input logic [31:0] d, input logic r, input logic cl);
    cap = c; ext_data = d; out_ready = r; clear = cl;
    @(posedge clk);
    #1;
  endtask
  task automatic chk_all(input string tag, input logic v, input logic [31:0] d, input logic [2:0] c,
                         input logic ov, input logic [7:0] dc);
    chk({tag, ".valid"}, 64'(out_valid), 64'(v));
    chk({tag, ".data"}, 64'(out_data), 64'(d));
    chk({tag, ".count"}, 64'(count), 64'(c));
    chk({tag, ".overflow"}, 64'(overflow), 64'(ov));
    chk({tag, ".drop_cnt"}, 64'(drop_cnt), 64'(dc));
  endtask
  function automatic vec_t mk(logic c, logic cl, logic r, logic [31:0] d, logic ev, logic [31:0] ed,
                              logic [2:0] ec, logic eov, logic [7:0] edc);
    mk = '{c, cl, r, d, ev, ed, ec, eov, edc};
  endfunction
  initial begin
    tv[0]  = mk(1, 0, 0, 32'hA5A5_0001, 1, 32'hA5A5_0001, 1, 0, 0);
    tv[1]  = mk(0, 0, 1, 0, 0, 0, 0, 0, 0);
    tv[2]  = mk(1, 0, 0, 1, 1, 1, 1, 0, 0);
    tv[3]  = mk(1, 0, 0, 2, 1, 1, 2, 0, 0);
    tv[4]  = mk(1, 0, 0, 3, 1, 1, 3, 0, 0);
    tv[5]  = mk(1, 0, 0, 4, 1, 1, 4, 0, 0);
    tv[6]  = mk(1, 0, 0, 5, 1, 1, 4, 1, 1);
    tv[7]  = mk(1, 0, 0, 6, 1, 1, 4, 1, 2);
    tv[8]  = mk(0, 0, 1, 0, 1, 2, 3, 1, 2);
    tv[9]  = mk(0, 0, 1, 0, 1, 3, 2, 1, 2);
    tv[10] = mk(0, 0, 1, 0, 1, 4, 1, 1, 2);
    tv[11] = mk(0, 0, 1, 0, 0, 0, 0, 1, 2);
    tv[12] = mk(0, 1, 0, 0, 0, 0, 0, 0, 0);
    tv[13] = mk(1, 0, 0, 1, 1, 1, 1, 0, 0);
    tv[14] = mk(1, 0, 0, 2, 1, 1, 2, 0, 0);
    tv[15] = mk(1, 0, 0, 3, 1, 1, 3, 0, 0);
    tv[16] = mk(1, 0, 0, 4, 1, 1, 4, 0, 0);
    tv[17] = mk(1, 0, 1, 9, 1, 2, 4, 0, 0);
    tv[18] = mk(0, 0, 1, 0, 1, 3, 3, 0, 0);
    tv[19] = mk(0, 0, 1, 0, 1, 4, 2, 0, 0);
    tv[20] = mk(0, 0, 1, 0, 1, 9, 1, 0, 0);
    tv[21] = mk(0, 0, 1, 0, 0, 0, 0, 0, 0);
    #1;
    chk_all("reset", 0, 0, 0, 0, 0);
    #11 rst = 0;
    for (int i = 0; i < 22; i++) begin
      cyc(tv[i].cap, tv[i].d, tv[i].rdy, tv[i].clr);
      chk_all($sformatf("vec%0d", i), tv[i].ev, tv[i].ed, tv[i].ec, tv[i].eov, tv[i].edc);
    end
    for (int i = 0; i < 80; i++) begin
      logic c, r, p, w;
      c = (i < 20) ? 1'b1 : (1'($urandom_range(0, 1)) && q.size() < 4);
      r = (i < 20) ? 1'b1 : 1'($urandom_range(0, 1));
      cap = c; ext_data = 32'h100 + i; out_ready = r; clear = 0;
      #1;
      chk($sformatf("wrap%0d.valid", i), 64'(out_valid), 64'(q.size() != 0));
      chk($sformatf("wrap%0d.data", i), 64'(out_data), 64'(q.size() != 0 ? q[0] : 32'h0));
      chk($sformatf("wrap%0d.count", i), 64'(count), 64'(q.size()));
      p = r && q.size() != 0;
      w = c && (q.size() < 4 || p);
      @(posedge clk);
      #1;
      if (p) void'(q.pop_front());
      if (w) q.push_back(32'h100 + i);
    end
    chk("wrap.overflow", 64'(overflow), 0);
    chk("wrap.drop_cnt", 64'(drop_cnt), 0);
    cyc(0, 0, 0, 1);
    q.delete();
    for (int i = 1; i <= 5; i++) cyc(1, i, 0, 0);
    cyc(0, 0, 1, 0);
    chk_all("pre_clear", 1, 2, 3, 1, 1);
    cyc(1, 32'hDEAD, 0, 1);
    chk_all("clear_cap", 0, 0, 0, 0, 0);
    cyc(1, 32'h11, 0, 0);
    cyc(1, 32'h22, 0, 0);
    cap = 0;
    #2 rst = 1;
    #1 chk_all("async_rst", 0, 0, 0, 0, 0);
    #1 rst = 0;
    cyc(1, 32'h77, 0, 0);
    chk_all("first_cap", 1, 32'h77, 1, 0, 0);
    cyc(0, 0, 1, 0);
    chk_all("no_stale", 0, 0, 0, 0, 0);
    for (int i = 1; i <= 4; i++) cyc(1, 32'hC0 + i, 0, 0);
    for (int i = 0; i < 300; i++) cyc(1, 32'hEE00 + i, 0, 0);
    chk_all("sat", 1, 32'hC1, 4, 1, 8'hff);
    for (int i = 1; i <= 4; i++) begin
      chk($sformatf("sat_drain%0d", i), 64'(out_data), 64'(32'hC0 + i));
      cyc(0, 0, 1, 0);
    end
    chk_all("sat_end", 0, 0, 0, 1, 8'hff);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ext_snapshot_fifo.md
EXT_SNAPSHOT_FIFO -- requirements
Module: ext_snapshot_fifo

Purpose: downstream consumer of a register exported to top level by make_external. Samples the exported value on request, buffers the samples, and drains them over a valid/ready port.

Interface
REQ-001 Parameter WIDTH, default 32, bit width of the exported register value.
REQ-002 Parameter DEPTH, default 4, number of snapshot entries; SHALL be a power of 2 and at least 2.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 ext_data  input  WIDTH  exported register value to be sampled.
REQ-006 cap  input  1  capture request; each cycle it is high requests one snapshot.
REQ-007 clear  input  1  synchronous flush of buffer and status.
REQ-008 out_valid  output  1  head snapshot available.
REQ-009 out_ready  input  1  consumer accepts head snapshot.
REQ-010 out_data  output  WIDTH  head snapshot value.
REQ-011 count  output  $clog2(DEPTH)+1  number of stored entries.
REQ-012 overflow  output  1  sticky flag: a capture was dropped.
REQ-013 drop_cnt  output  8  number of dropped captures, saturating.

Function
REQ-014 Capture: when cap=1 at a rising edge and the buffer accepts, the value of ext_data sampled at that same edge SHALL be written at the tail.
REQ-015 A captured entry SHALL be visible at the head no later than one cycle after capture: out_valid=1 in the cycle after the capture edge if the buffer was empty.
REQ-016 Pop: a transfer SHALL occur at an edge where out_valid=1 and out_ready=1; the head SHALL advance by one entry.
REQ-017 out_valid SHALL equal (count != 0), and out_data SHALL equal the head entry while out_valid=1.
REQ-018 out_data SHALL be all zeros while out_valid=0.
REQ-019 Once out_valid is asserted, out_data SHALL remain stable until the transfer completes; this does not depend on out_ready.
REQ-020 Ordering SHALL be strictly FIFO; read and write pointers SHALL wrap modulo DEPTH.
REQ-021 Full (count=DEPTH), cap=1 and no pop in the same cycle:
- the capture SHALL be dropped;
- stored contents SHALL be unchanged;
- overflow SHALL be set to 1;
- drop_cnt SHALL increment, saturating at 255.
REQ-022 Full, with cap=1 and a pop at the same edge: the capture SHALL be accepted, count SHALL stay at DEPTH, and no drop is recorded.
REQ-023 Simultaneous capture and pop when not empty and not full: count SHALL be unchanged and both operations SHALL take effect.
REQ-024 Empty with cap=1: the entry SHALL be written. No pop can occur in that cycle, because out_valid=0.
REQ-025 count SHALL change by +1 (capture only), -1 (pop only), or 0 (both or neither) per edge.
REQ-026 clear=1 at an edge SHALL have priority over cap and pop in the same cycle:
- count SHALL go to 0 and pointers SHALL go to 0;
- overflow SHALL go to 0 and drop_cnt SHALL go to 0;
- cap and pop in that same cycle SHALL be ignored.
REQ-027 overflow SHALL remain 1 until clear or rst.
REQ-028 drop_cnt SHALL remain at 255 until clear or rst once saturated.
REQ-029 The block SHALL have no combinational path from cap or ext_data to any output.
REQ-030 out_valid SHALL NOT depend combinationally on out_ready.

Reset
REQ-031 While rst=1, and immediately on its assertion independent of clk, all of the following SHALL hold:
- count=0, out_valid=0, out_data=0;
- overflow=0, drop_cnt=0;
- read and write pointers=0.
REQ-032 Reset asserted mid-operation SHALL discard all stored entries; no pre-reset entry SHALL appear after rst deasserts.
REQ-033 The first capture SHALL be honoured at the first rising edge after rst deasserts.
REQ-034 Memory contents need not be reset; unwritten entries SHALL never be visible on out_data.

Verification
REQ-035 Basic path: rst, then cap for 1 cycle with ext_data=32'hA5A5_0001, out_ready=0 -> next cycle out_valid=1, out_data=32'hA5A5_0001, count=1; then out_ready=1 for 1 cycle -> out_valid=0, out_data=0, count=0.
REQ-036 Fill and overflow: 6 consecutive caps with values 1..6, out_ready=0 -> count=4, overflow=1, drop_cnt=2; drain yields 1,2,3,4 in order.
REQ-037 Full with simultaneous cap and pop: fill with 1..4, then cap with value 9 and out_ready=1 for 1 cycle -> 1 popped, count=4, overflow=0; drain yields 2,3,4,9.
REQ-038 Wrap and stall: 20 caps with continuous out_ready=1, then random out_ready stalls -> all 20 values delivered in order, no drops; out_data stable while out_valid=1 and out_ready=0.
REQ-039 Clear and reset: with count=3 and overflow=1, assert clear together with cap -> count=0, overflow=0, drop_cnt=0, capture ignored; repeat with rst asserted between clock edges -> outputs zero before the next edge.
REQ-040 Saturation: 300 caps while full with no pops -> drop_cnt=255, overflow=1, stored entries unchanged.
